mem_io_access_ctrl: RTL
=======================

# mem_io_access_ctrl

Multi-cycle access sequencer between the MEM stage and the data-side resources: synchronous data memory (BRAM, fixed read latency) and memory-mapped IO devices with a ready handshake. It latches one CPU load/store, stalls the pipeline until completion, and arbitrates data-memory write access with the UART program loader. It replaces the purely combinational address decode with a single-outstanding-transaction controller.

## Interface
- IO_PREFIX, 24'hFFFFFC, address bits [31:8] that select IO space
- MEM_RD_LAT, 1, data-memory read latency in cycles (legal 1..3)
- IO_TIMEOUT, 255, max cycles to wait for io_ready (legal 1..1023)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- cpu_req  in  1  MEM-stage access request (mRead or mWrite)
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  32  byte address from ALU
- cpu_wdata  in  32  store data
- cpu_rdata  out  32  load data, registered, held until next completion
- cpu_stall  out  1  pipeline stall
- cpu_done  out  1  one-cycle completion pulse
- cpu_err  out  1  one-cycle pulse with cpu_done on IO timeout
- ld_req  in  1  loader write request (always memory space)
- ld_addr  in  32  loader address
- ld_wdata  in  32  loader data
- ld_gnt  out  1  one-cycle pulse: loader write issued
- mem_en, mem_we  out  1 each  data-memory enable / write enable
- mem_addr, mem_wdata  out  32 each  data-memory address / write data
- mem_rdata  in  32  data-memory read data
- io_en, io_we  out  1 each  IO access strobe / write
- io_addr, io_wdata  out  32 each  IO address / write data
- io_rdata  in  32  IO read data
- io_ready  in  1  device accepts/returns data this cycle

## Operation
- States: IDLE, MEM_ISSUE, MEM_WAIT, IO_WAIT, LD_ISSUE, DONE.
- IDLE: ld_req has priority -> latch ld_addr/ld_wdata, go LD_ISSUE. Else cpu_req -> latch addr/wdata/we; is_io = (cpu_addr[31:8] == IO_PREFIX); go IO_WAIT if is_io else MEM_ISSUE.
- LD_ISSUE: mem_en=mem_we=1, ld_gnt=1; -> IDLE.
- MEM_ISSUE: mem_en=1, mem_we=latched we; store -> DONE; load -> MEM_WAIT, counter loaded with MEM_RD_LAT.
- MEM_WAIT: counter decrements; at 0 capture mem_rdata into cpu_rdata, -> DONE.
- IO_WAIT: io_en=1 held, io_we/addr/wdata stable; io_ready=1 -> capture io_rdata (loads only), -> DONE. Counter reaches IO_TIMEOUT without ready -> cpu_rdata=0, cpu_err=1 in DONE.
- DONE: cpu_done=1; -> IDLE unconditionally.
- cpu_stall = cpu_req & ~cpu_done (combinational); also 1 in any non-IDLE state except DONE.
- cpu_req dropping mid-transaction does not abort; done still pulses.
- ld_req arriving during a CPU transaction waits until IDLE; CPU arriving with ld_req pending stalls through the loader write.
- Stores never modify cpu_rdata.
- Memory and IO outputs are 0 whenever not in the state that drives them.

## Timing
- All outputs except cpu_stall are registered; reset value of every output is 0, state IDLE, counters 0.
- Request sampled in IDLE cycle N.
- Memory store: mem_en high cycle N+1, cpu_done cycle N+2.
- Memory load: mem_en high cycle N+1, mem_rdata sampled cycle N+1+MEM_RD_LAT, cpu_done/cpu_rdata valid cycle N+2+MEM_RD_LAT.
- IO: io_en high from N+1; io_ready seen in cycle M -> cpu_done at M+1. Timeout: cpu_done+cpu_err at N+2+IO_TIMEOUT.
- Loader: ld_gnt and mem write in cycle N+1, controller back in IDLE at N+2.
- A cpu_req still high in the cycle after DONE is a new transaction.
- Reset asserted mid-transaction: immediate return to IDLE, all strobes drop, transaction lost, no done pulse.

## Test plan
- Store 0x12345678 to 0x00000010, cpu_req at cycle 0 -> mem_en=mem_we=1 cycle 1, cpu_done cycle 2, cpu_stall high cycles 0-1.
- Load 0x00000010, MEM_RD_LAT=1, mem_rdata=0xCAFEBABE -> cpu_rdata=0xCAFEBABE with cpu_done cycle 3, err=0.
- Load 0xFFFFFC70 (switch), io_ready high at cycle 4 with io_rdata=0x00000ABC -> cpu_done cycle 5, cpu_rdata=0x00000ABC.
- IO store 0xFFFFFC60, io_ready held 0, IO_TIMEOUT=8 -> io_en high cycles 1-9, cpu_done+cpu_err cycle 10, cpu_rdata=0.
- ld_req and cpu_req both at cycle 0 -> ld_gnt cycle 1, CPU issue cycle 3, cpu_stall high until done.
- rst_n low during MEM_WAIT -> all outputs 0 same cycle, no cpu_done, next request handled normally.

Source files
------------

// File: rtl/mem_io_access_ctrl_if.sv
// Bundle of the CPU, program-loader, data-memory and IO-device signals seen by the
// data-side access controller; "slave" is the controller's view, "master" its environment.
interface mem_io_access_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        cpu_done;
    logic        cpu_err;

    logic        ld_req;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic        ld_gnt;

    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        io_en;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [31:0] io_rdata;
    logic        io_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall, cpu_done, cpu_err,
        input  ld_req, ld_addr, ld_wdata,
        output ld_gnt,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output io_en, io_we, io_addr, io_wdata,
        input  io_rdata, io_ready
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall, cpu_done, cpu_err,
        output ld_req, ld_addr, ld_wdata,
        input  ld_gnt,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  io_en, io_we, io_addr, io_wdata,
        output io_rdata, io_ready
    );
endinterface

// File: rtl/mem_io_access_ctrl.sv
// Single-outstanding load/store sequencer between the MEM stage and the data BRAM / IO
// devices; also slots UART loader writes into the data memory when the CPU side is idle.
module mem_io_access_ctrl #(
    parameter logic [23:0] IO_PREFIX  = 24'hFFFFFC,
    parameter int unsigned MEM_RD_LAT = 1,
    parameter int unsigned IO_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mem_io_access_ctrl_if.slave        bus
);

    localparam int CNT_W = 10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MEM_ISSUE,
        S_MEM_WAIT,
        S_IO_WAIT,
        S_LD_ISSUE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_d;

    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              io_en_q, io_en_d;
    logic              io_we_q, io_we_d;
    logic [31:0]       io_addr_q, io_addr_d;
    logic [31:0]       io_wdata_q, io_wdata_d;
    logic              ld_gnt_q, ld_gnt_d;
    logic              done_q, done_d;
    logic              err_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state and transaction datapath.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first, so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ld_req) begin
                    addr_d  = bus.ld_addr;
                    wdata_d = bus.ld_wdata;
                    we_d    = 1'b1;
                    state_d = S_LD_ISSUE;
                end else if (bus.cpu_req) begin
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                    we_d    = bus.cpu_we;
                    cnt_d   = '0;
                    state_d = (bus.cpu_addr[31:8] == IO_PREFIX) ? S_IO_WAIT : S_MEM_ISSUE;
                end
            end
            S_LD_ISSUE: state_d = S_IDLE;
            S_MEM_ISSUE: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    // Zero-based so MEM_WAIT lasts exactly MEM_RD_LAT cycles.
                    cnt_d   = CNT_W'(MEM_RD_LAT - 1);
                    state_d = S_MEM_WAIT;
                end
            end
            S_MEM_WAIT: begin
                if (cnt_q == '0) begin
                    rdata_d = bus.mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_IO_WAIT: begin
                // A ready in the final allowed cycle still wins over the timeout.
                if (bus.io_ready) begin
                    if (!we_q) rdata_d = bus.io_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_W'(IO_TIMEOUT)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state, so every strobe leaves a flop.
    always_comb begin
        mem_en_d    = (state_d == S_MEM_ISSUE) || (state_d == S_LD_ISSUE);
        mem_we_d    = (state_d == S_LD_ISSUE) || ((state_d == S_MEM_ISSUE) && we_d);
        mem_addr_d  = mem_en_d ? addr_d  : '0;
        mem_wdata_d = mem_we_d ? wdata_d : '0;
        io_en_d     = (state_d == S_IO_WAIT);
        io_we_d     = io_en_d && we_d;
        io_addr_d   = io_en_d ? addr_d  : '0;
        io_wdata_d  = io_we_d ? wdata_d : '0;
        ld_gnt_d    = (state_d == S_LD_ISSUE);
        done_d      = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            io_en_q     <= 1'b0;
            io_we_q     <= 1'b0;
            io_addr_q   <= '0;
            io_wdata_q  <= '0;
            ld_gnt_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            io_en_q     <= io_en_d;
            io_we_q     <= io_we_d;
            io_addr_q   <= io_addr_d;
            io_wdata_q  <= io_wdata_d;
            ld_gnt_q    <= ld_gnt_d;
            done_q      <= done_d;
        end
    end

    // Stall is the only combinational output; held low while reset is asserted.
    assign bus.cpu_stall = rst_n && ((bus.cpu_req && !done_q) ||
                                     ((state_q != S_IDLE) && (state_q != S_DONE)));

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.ld_gnt    = ld_gnt_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.io_en     = io_en_q;
    assign bus.io_we     = io_we_q;
    assign bus.io_addr   = io_addr_q;
    assign bus.io_wdata  = io_wdata_q;

endmodule
